coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Snoop-bus controller for the dual-core system. It is the responder to each core's coherence request outputs (read_miss, write_miss, invalidate, BICO, cpu_search_found, send_other_proc_data).
- It arbitrates between core 0 and core 1 round-robin and broadcasts search and invalidate operations to the non-requesting core.
- It returns grant, data source select and forwarded data to the requester.
- One instance sits between the two cpu instances and the unified memory.

Parameters:
- SNOOP_TIMEOUT, 4: cycles to wait in WAIT for cpu_search_found before declaring a miss; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- read_miss  input  2  per-core read miss request; bit i = core i
- write_miss  input  2  per-core write miss request
- invalidate  input  2  per-core invalidate (write hit on shared) request
- BICO0  input  11  core 0 block address
- BICO1  input  11  core 1 block address
- cpu_search_found  input  2  core i found the searched block
- send_data0  input  16  core 0 supplied data (its send_other_proc_data)
- send_data1  input  16  core 1 supplied data
- grant  output  2  one-cycle grant pulse to the requester
- cpu_search  output  2  one-cycle search strobe to the snooped core
- BOCI0  output  13  {bus_op[1:0], addr[10:0]} to core 0
- BOCI1  output  13  {bus_op[1:0], addr[10:0]} to core 1
- cpu_datasel0  output  2  data source for core 0: 00 none, 01 other core, 10 memory
- cpu_datasel1  output  2  data source for core 1, same encoding
- invalidate_other  output  2  one-cycle invalidate to core i (drives its invalidate_from_other_cpu)
- other_proc_data0  output  16  forwarded data to core 0
- other_proc_data1  output  16  forwarded data to core 1

Behaviour:
- Reset values: all outputs 0. State = IDLE. Round-robin pointer = core 0. Counter, latched op/addr/data/found all 0.
- bus_op encoding: 00 none, 01 read_miss, 10 write_miss, 11 invalidate.
- Per-core request priority: invalidate > write_miss > read_miss.
- All outputs are registered.
- States: IDLE, BCAST, WAIT, GRANT, HOLD.
- IDLE:
  - If any core has a request, select a core. If both request, the pointer core wins; otherwise the sole requester wins.
  - Latch req_id, op and that core's BICO. Go to BCAST.
- BCAST (1 cycle):
  - BOCI[other] = {op, addr}.
  - For read/write miss: cpu_search[other] = 1, go to WAIT, clear the counter.
  - For invalidate: go directly to GRANT with found = 0.
- WAIT:
  - Sample cpu_search_found[other] each cycle. When it is 1: latch send_data[other], found = 1, go to GRANT.
  - Otherwise increment the counter. When counter == SNOOP_TIMEOUT-1: found = 0, go to GRANT.
  - cpu_search_found[req_id] is ignored.
- GRANT (1 cycle):
  - grant[req_id] = 1.
  - cpu_datasel[req_id] = found ? 01 : 10. For invalidate op it is 00.
  - other_proc_data[req_id] = latched data when found, else 0.
  - invalidate_other[other] = 1 if op is write_miss or invalidate.
  - Go to HOLD.
- HOLD:
  - cpu_datasel and other_proc_data for req_id stay valid.
  - When all three request bits of req_id are 0: clear datasel and data, pointer = other core, go to IDLE.
- BOCI to the non-snooped core stays 0. BOCI[other] stays driven from BCAST through GRANT; it is 0 in IDLE.
- Latency: invalidate request to grant is 3 cycles. A miss with a found response on the first WAIT cycle is 4 cycles. A miss that times out is 3+SNOOP_TIMEOUT cycles.
- Request dropped before GRANT (in BCAST or WAIT): abandon the transaction. Return to IDLE next cycle with no grant and no invalidate; pointer unchanged.
- A request held past HOLD release is treated as a new request.
- Simultaneous requests from both cores: strictly one transaction at a time. The loser waits in IDLE arbitration.
- Request bits changing during a transaction do not alter the latched op or addr.
- rst_n low at any state: immediate return to reset values; no partial pulses.

Test Plan:
- Reset with rst_n=0 mid-WAIT -> all outputs 0 immediately; state IDLE; after release, no grant without a new request.
- Core 0 read_miss, BICO0=11'h123; core 1 asserts cpu_search_found on the first WAIT cycle with send_data1=16'hBEEF -> sequence:
  - cpu_search=2'b10, BOCI1=13'h0923.
  - grant=2'b01 at cycle 4.
  - cpu_datasel0=01, other_proc_data0=16'hBEEF held until read_miss[0] drops.
- Core 1 write_miss, addr 11'h7FF, no found -> grant[1] after 3+4=7 cycles; cpu_datasel1=10; invalidate_other=2'b01 in the grant cycle; other_proc_data1=0.
- Core 0 invalidate, addr 11'h040 -> no cpu_search; BOCI1=13'h1840; grant[0] and invalidate_other[1] in the same cycle, 3 cycles after the request; cpu_datasel0=00.
- Both cores read_miss in the same cycle, pointer=0 -> core 0 is served first. After release, core 1 is served; on the next simultaneous request, core 0 wins again.
- Core 0 read_miss dropped during WAIT -> no grant pulse, IDLE next cycle, pointer still 0.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Snoop-bus controller between two cores: round-robin arbitration, snoop broadcast,
// and grant/data-source return. Outputs are registered from the current state.
module coherence_bus_ctrl #(
    parameter int SNOOP_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  read_miss,
    input  logic [1:0]  write_miss,
    input  logic [1:0]  invalidate,
    input  logic [10:0] BICO0,
    input  logic [10:0] BICO1,
    input  logic [1:0]  cpu_search_found,
    input  logic [15:0] send_data0,
    input  logic [15:0] send_data1,
    output logic [1:0]  grant,
    output logic [1:0]  cpu_search,
    output logic [12:0] BOCI0,
    output logic [12:0] BOCI1,
    output logic [1:0]  cpu_datasel0,
    output logic [1:0]  cpu_datasel1,
    output logic [1:0]  invalidate_other,
    output logic [15:0] other_proc_data0,
    output logic [15:0] other_proc_data1
);
    typedef enum logic [2:0] {IDLE, BCAST, WAIT, GRANT, HOLD} state_t;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;
    localparam logic [3:0] CNT_LAST = 4'(SNOOP_TIMEOUT - 1);

    state_t      state, state_n;
    logic        ptr, ptr_n, req_id, req_id_n, found, found_n;
    logic [1:0]  op, op_n;
    logic [10:0] addr, addr_n;
    logic [15:0] data, data_n;
    logic [3:0]  cnt, cnt_n;

    logic [1:0]        grant_d, search_d, inv_d;
    logic [1:0][1:0]   dsel_d, dsel_q;
    logic [1:0][12:0]  boci_d, boci_q;
    logic [1:0][15:0]  opd_d, opd_q;
    logic [1:0]        grant_q, search_q, inv_q;

    logic [1:0]  req_vec;
    logic        oth, sel, req_live;
    logic [1:0]  res_dsel;
    logic [15:0] res_data;

    always_comb begin
        req_vec  = read_miss | write_miss | invalidate;
        oth      = ~req_id;
        req_live = req_vec[req_id];
        sel      = (req_vec == 2'b11) ? ptr : req_vec[1];
        res_dsel = (op == OP_INV) ? 2'b00 : (found ? 2'b01 : 2'b10);
        res_data = found ? data : 16'h0000;

        state_n  = state;
        ptr_n    = ptr;
        req_id_n = req_id;
        op_n     = op;
        addr_n   = addr;
        data_n   = data;
        found_n  = found;
        cnt_n    = cnt;
        grant_d  = '0;
        search_d = '0;
        inv_d    = '0;
        dsel_d   = '0;
        boci_d   = '0;
        opd_d    = '0;

        case (state)
            IDLE: begin
                if (|req_vec) begin
                    req_id_n = sel;
                    op_n     = invalidate[sel] ? OP_INV :
                               write_miss[sel] ? OP_WR  : OP_RD;
                    addr_n   = sel ? BICO1 : BICO0;
                    data_n   = '0;
                    found_n  = 1'b0;
                    state_n  = BCAST;
                end
            end
            BCAST: begin
                // A dropped request abandons the transaction with outputs cleared.
                if (!req_live) begin
                    state_n = IDLE;
                end else begin
                    boci_d[oth] = {op, addr};
                    if (op == OP_INV) begin
                        found_n = 1'b0;
                        state_n = GRANT;
                    end else begin
                        search_d[oth] = 1'b1;
                        cnt_n         = '0;
                        state_n       = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_live) begin
                    state_n = IDLE;
                end else begin
                    boci_d[oth] = {op, addr};
                    if (cpu_search_found[oth]) begin
                        data_n  = oth ? send_data1 : send_data0;
                        found_n = 1'b1;
                        state_n = GRANT;
                    end else if (cnt == CNT_LAST) begin
                        found_n = 1'b0;
                        state_n = GRANT;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            GRANT: begin
                boci_d[oth]    = {op, addr};
                grant_d[req_id] = 1'b1;
                dsel_d[req_id]  = res_dsel;
                opd_d[req_id]   = res_data;
                inv_d[oth]      = (op == OP_WR) || (op == OP_INV);
                state_n         = HOLD;
            end
            HOLD: begin
                if (!req_live) begin
                    ptr_n   = oth;
                    state_n = IDLE;
                end else begin
                    dsel_d[req_id] = res_dsel;
                    opd_d[req_id]  = res_data;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            req_id   <= 1'b0;
            op       <= '0;
            addr     <= '0;
            data     <= '0;
            found    <= 1'b0;
            cnt      <= '0;
            grant_q  <= '0;
            search_q <= '0;
            inv_q    <= '0;
            dsel_q   <= '0;
            boci_q   <= '0;
            opd_q    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            req_id   <= req_id_n;
            op       <= op_n;
            addr     <= addr_n;
            data     <= data_n;
            found    <= found_n;
            cnt      <= cnt_n;
            grant_q  <= grant_d;
            search_q <= search_d;
            inv_q    <= inv_d;
            dsel_q   <= dsel_d;
            boci_q   <= boci_d;
            opd_q    <= opd_d;
        end
    end

    assign grant            = grant_q;
    assign cpu_search       = search_q;
    assign invalidate_other = inv_q;
    assign BOCI0            = boci_q[0];
    assign BOCI1            = boci_q[1];
    assign cpu_datasel0     = dsel_q[0];
    assign cpu_datasel1     = dsel_q[1];
    assign other_proc_data0 = opd_q[0];
    assign other_proc_data1 = opd_q[1];
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with hand-computed cycle-accurate expectations.
module tb_coherence_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  read_miss, write_miss, invalidate, cpu_search_found;
    logic [10:0] BICO0, BICO1;
    logic [15:0] send_data0, send_data1;
    logic [1:0]  grant, cpu_search, cpu_datasel0, cpu_datasel1, invalidate_other;
    logic [12:0] BOCI0, BOCI1;
    logic [15:0] other_proc_data0, other_proc_data1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    coherence_bus_ctrl #(.SNOOP_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
        .BICO0(BICO0), .BICO1(BICO1), .cpu_search_found(cpu_search_found),
        .send_data0(send_data0), .send_data1(send_data1),
        .grant(grant), .cpu_search(cpu_search), .BOCI0(BOCI0), .BOCI1(BOCI1),
        .cpu_datasel0(cpu_datasel0), .cpu_datasel1(cpu_datasel1),
        .invalidate_other(invalidate_other),
        .other_proc_data0(other_proc_data0), .other_proc_data1(other_proc_data1)
    );

    wire [67:0] all_out = {grant, cpu_search, BOCI0, BOCI1, cpu_datasel0, cpu_datasel1,
                           invalidate_other, other_proc_data0, other_proc_data1};

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_inputs;
        read_miss = '0; write_miss = '0; invalidate = '0; cpu_search_found = '0;
        BICO0 = '0; BICO1 = '0; send_data0 = '0; send_data1 = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clr_inputs();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Steps until a grant pulse appears; n = cycles taken, or -1 on expiry.
    task automatic wait_grant(input int limit, output logic [1:0] g, output int n);
        g = '0;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc(1);
            if (grant != 2'b00) begin
                g = grant;
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int seen;
        rst_n = 1'b0;
        clr_inputs();
        cyc(2);
        total++; if (all_out !== 68'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
        rst_n = 1'b1;
        cyc(1);
        read_miss = 2'b01; BICO0 = 11'h055;
        cyc(2);
        total++; if (cpu_search !== 2'b10) begin bad++; $display("FAIL reset_prewait_search got=%b want=10", cpu_search); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (all_out !== 68'h0) begin bad++; $display("FAIL reset_midwait got=%h want=0", all_out); end
        read_miss = 2'b00;
        cyc(1);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (grant != 2'b00 || cpu_search != 2'b00) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_grant got=%0d want=0 active cycles", seen); end
    endtask

    task automatic test_read_miss_found;
        do_reset();
        read_miss = 2'b01; BICO0 = 11'h123;
        cyc(1);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rd_c1_grant got=%b want=00", grant); end
        cyc(1);
        total++; if (cpu_search !== 2'b10) begin bad++; $display("FAIL rd_search got=%b want=10", cpu_search); end
        total++; if (BOCI1 !== 13'h0923) begin bad++; $display("FAIL rd_boci1 got=%h want=0923", BOCI1); end
        total++; if (BOCI0 !== 13'h0000) begin bad++; $display("FAIL rd_boci0 got=%h want=0000", BOCI0); end
        cpu_search_found = 2'b11; send_data1 = 16'hBEEF; send_data0 = 16'h1111;
        cyc(1);
        cpu_search_found = 2'b00; send_data1 = 16'h0000;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rd_c3_grant got=%b want=00", grant); end
        cyc(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b want=01", grant); end
        total++; if (cpu_datasel0 !== 2'b01) begin bad++; $display("FAIL rd_datasel0 got=%b want=01", cpu_datasel0); end
        total++; if (other_proc_data0 !== 16'hBEEF) begin bad++; $display("FAIL rd_data0 got=%h want=beef", other_proc_data0); end
        total++; if (invalidate_other !== 2'b00) begin bad++; $display("FAIL rd_inv got=%b want=00", invalidate_other); end
        cyc(2);
        total++; if (grant !== 2'b00 || cpu_datasel0 !== 2'b01 || other_proc_data0 !== 16'hBEEF)
            begin bad++; $display("FAIL rd_hold got=%b/%b/%h want=00/01/beef", grant, cpu_datasel0, other_proc_data0); end
        read_miss = 2'b00;
        cyc(2);
        total++; if (cpu_datasel0 !== 2'b00 || other_proc_data0 !== 16'h0)
            begin bad++; $display("FAIL rd_release got=%b/%h want=00/0000", cpu_datasel0, other_proc_data0); end
    endtask

    task automatic test_write_miss_timeout;
        int early;
        do_reset();
        write_miss = 2'b10; BICO1 = 11'h7FF;
        early = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (grant != 2'b00) early++;
            if (k == 2) begin
                total++; if (cpu_search !== 2'b01 || BOCI0 !== 13'h17FF || BOCI1 !== 13'h0)
                    begin bad++; $display("FAIL wr_bcast got=%b/%h/%h want=01/17ff/0000", cpu_search, BOCI0, BOCI1); end
            end
        end
        total++; if (early !== 0) begin bad++; $display("FAIL wr_early_grant got=%0d want=0", early); end
        cyc(1);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL wr_grant got=%b want=10", grant); end
        total++; if (cpu_datasel1 !== 2'b10) begin bad++; $display("FAIL wr_datasel1 got=%b want=10", cpu_datasel1); end
        total++; if (invalidate_other !== 2'b01) begin bad++; $display("FAIL wr_inv got=%b want=01", invalidate_other); end
        total++; if (other_proc_data1 !== 16'h0) begin bad++; $display("FAIL wr_data1 got=%h want=0000", other_proc_data1); end
        write_miss = 2'b00;
        cyc(2);
    endtask

    task automatic test_invalidate;
        do_reset();
        invalidate = 2'b01; BICO0 = 11'h040;
        cyc(1);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL inv_c1_grant got=%b want=00", grant); end
        cyc(1);
        total++; if (BOCI1 !== 13'h1840 || cpu_search !== 2'b00 || grant !== 2'b00)
            begin bad++; $display("FAIL inv_bcast got=%h/%b/%b want=1840/00/00", BOCI1, cpu_search, grant); end
        cyc(1);
        total++; if (grant !== 2'b01 || invalidate_other !== 2'b10 || cpu_datasel0 !== 2'b00)
            begin bad++; $display("FAIL inv_grant got=%b/%b/%b want=01/10/00", grant, invalidate_other, cpu_datasel0); end
        invalidate = 2'b00;
        cyc(2);
    endtask

    task automatic test_back_to_back;
        logic [1:0] g;
        int n;
        do_reset();
        read_miss = 2'b11; BICO0 = 11'h001; BICO1 = 11'h002;
        wait_grant(20, g, n);
        total++; if (g !== 2'b01 || n !== 7) begin bad++; $display("FAIL arb_first got=%b@%0d want=01@7", g, n); end
        read_miss = 2'b10;
        wait_grant(20, g, n);
        total++; if (g !== 2'b10) begin bad++; $display("FAIL arb_second got=%b want=10", g); end
        read_miss = 2'b00;
        cyc(2);
        read_miss = 2'b11;
        wait_grant(20, g, n);
        total++; if (g !== 2'b01) begin bad++; $display("FAIL arb_third got=%b want=01", g); end
        read_miss = 2'b00;
        cyc(2);
    endtask

    task automatic test_drop;
        logic [1:0] g;
        int n, seen;
        do_reset();
        read_miss = 2'b01; BICO0 = 11'h200;
        cyc(2);
        total++; if (cpu_search !== 2'b10) begin bad++; $display("FAIL drop_search got=%b want=10", cpu_search); end
        read_miss = 2'b00;
        cyc(1);
        total++; if (cpu_search !== 2'b00 || BOCI1 !== 13'h0)
            begin bad++; $display("FAIL drop_clear got=%b/%h want=00/0000", cpu_search, BOCI1); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (grant != 2'b00 || invalidate_other != 2'b00) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL drop_no_grant got=%0d want=0", seen); end
        read_miss = 2'b11;
        wait_grant(20, g, n);
        total++; if (g !== 2'b01) begin bad++; $display("FAIL drop_ptr got=%b want=01", g); end
        read_miss = 2'b00;
        cyc(2);
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_read_miss_found();
        test_write_miss_timeout();
        test_invalidate();
        test_back_to_back();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
